// File: rtl/mdu_iterative.sv
// Iterative RV32M multiply/divide unit. It processes one operand bit per CALC cycle,
// finishes sign and special-case handling in FIX, and then pulses done with a write request.
module mdu_iterative #(
  parameter int XLEN         = 32,
  parameter bit SPECIAL_FAST = 1'b1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic [4:0]      rd_addr,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic [4:0]      wb_addr,
  output logic            wb_en
);

  localparam int CW = $clog2(XLEN);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t state, state_next;

  logic [2:0]      op;
  logic [XLEN-1:0] a_raw;
  logic [XLEN-1:0] b_mag;
  logic [2*XLEN-1:0] acc;
  logic            a_neg, b_neg, div_zero, overflow;
  logic [CW-1:0]   cnt;

  logic            accept;
  logic            a_signed_in, b_signed_in, a_neg_in, b_neg_in;
  logic            div_zero_in, overflow_in, special_in;
  logic [XLEN-1:0] a_mag_in, b_mag_in;

  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] mul_step;
  logic [XLEN:0]     div_shifted, div_trial;
  logic [2*XLEN-1:0] div_step;
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   quo, rem;
  logic [XLEN-1:0]   fix_result;

  // A new request is taken only while idle; requests in other states are dropped.
  assign accept = (state == IDLE) && start;

  // Signedness follows the RV32M op table: rs1 is signed except for MULHU/DIVU/REMU,
  // and rs2 is signed only for MUL/MULH/DIV/REM.
  assign a_signed_in = funct3[2] ? ~funct3[0] : (funct3[1:0] != 2'b11);
  assign b_signed_in = funct3[2] ? ~funct3[0] : ~funct3[1];
  assign a_neg_in    = a_signed_in & rs1_data[XLEN-1];
  assign b_neg_in    = b_signed_in & rs2_data[XLEN-1];
  assign a_mag_in    = a_neg_in ? -rs1_data : rs1_data;
  assign b_mag_in    = b_neg_in ? -rs2_data : rs2_data;
  assign div_zero_in = funct3[2] & (rs2_data == '0);
  assign overflow_in = funct3[2] & ~funct3[0] & (rs1_data == {1'b1, {(XLEN-1){1'b0}}})
                       & (rs2_data == '1);
  assign special_in  = SPECIAL_FAST & (div_zero_in | overflow_in);

  // Multiply step: add the multiplicand into the upper half when the multiplier LSB is set, then shift right.
  assign mul_sum  = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, b_mag} : '0);
  assign mul_step = {mul_sum, acc[XLEN-1:1]};

  // Restoring divide step: the upper half holds the partial remainder and the lower half shifts the dividend out and the quotient in.
  assign div_shifted = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
  assign div_trial   = div_shifted - {1'b0, b_mag};
  assign div_step    = div_trial[XLEN]
                       ? {div_shifted[XLEN-1:0], acc[XLEN-2:0], 1'b0}
                       : {div_trial[XLEN-1:0],   acc[XLEN-2:0], 1'b1};

  // Fix-up: apply the result sign, select the half or quotient/remainder, and override special cases.
  always_comb begin
    prod       = (a_neg ^ b_neg) ? -acc : acc;
    quo        = acc[XLEN-1:0];
    rem        = acc[2*XLEN-1:XLEN];
    fix_result = '0;
    if (!op[2]) begin
      fix_result = (op[1:0] == 2'b00) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
    end else if (div_zero) begin
      fix_result = op[1] ? a_raw : '1;
    end else if (overflow) begin
      fix_result = op[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
    end else if (op[1]) begin
      fix_result = a_neg ? -rem : rem;
    end else begin
      fix_result = (a_neg ^ b_neg) ? -quo : quo;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state logic and status outputs.
  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: if (start) state_next = special_in ? FIX : CALC;
      CALC: begin
        busy = 1'b1;
        if (cnt == '0) state_next = FIX;
      end
      FIX: begin
        busy       = 1'b1;
        state_next = DONE;
      end
      DONE: begin
        busy       = 1'b1;
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign wb_en = done && (wb_addr != 5'd0);

  // Datapath: latch the operands at accept, iterate in CALC, and register the result in FIX.
  always_ff @(posedge clk) begin
    if (reset) begin
      op       <= '0;
      a_raw    <= '0;
      b_mag    <= '0;
      acc      <= '0;
      a_neg    <= 1'b0;
      b_neg    <= 1'b0;
      div_zero <= 1'b0;
      overflow <= 1'b0;
      cnt      <= '0;
      result   <= '0;
      wb_addr  <= '0;
    end else if (accept) begin
      op       <= funct3;
      a_raw    <= rs1_data;
      b_mag    <= b_mag_in;
      acc      <= {{XLEN{1'b0}}, a_mag_in};
      a_neg    <= a_neg_in;
      b_neg    <= b_neg_in;
      div_zero <= div_zero_in;
      overflow <= overflow_in;
      cnt      <= CW'(XLEN - 1);
      wb_addr  <= rd_addr;
    end else if (state == CALC) begin
      acc <= op[2] ? div_step : mul_step;
      cnt <= cnt - 1'b1;
    end else if (state == FIX) begin
      result <= fix_result;
    end
  end

endmodule
